// File: rtl/switch_io_pkg.sv
// Shared constants for the DIP switch input stage.
// Optional change flag is enabled by defining SWITCH_CHANGE_FLAG_EN.
package switch_io_pkg;

    localparam int SW_WIDTH = 24;

    localparam logic [1:0] SW_OFF_LO = 2'b00;
    localparam logic [1:0] SW_OFF_HI = 2'b10;

    localparam int FLAG_BIT = 15;

    // Counter width for a 0..n-1 counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchronizer plus a tick-driven stable counter.
// The debounced value flips only after STABLE_TICKS consecutive mismatching ticks.
module switch_debounce_bit
    import switch_io_pkg::*;
#(
    parameter int STABLE_TICKS = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_i,
    input  logic raw_i,
    output logic deb_o,
    output logic flip_o
);

    localparam int CW = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next-state for the stable counter and debounced value.
    always_comb begin
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        flip_o = 1'b0;
        if (tick_i) begin
            if (sync2_q == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                deb_d  = sync2_q;
                cnt_d  = '0;
                flip_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer flops and debounce state.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/switch_io.sv
// Debounced DIP switch port at FFFFFC70 (low 16) / FFFFFC72 (high 8).
// Define SWITCH_CHANGE_FLAG_EN to add a sticky change flag in bit 15 of the high word.
module switch_io
    import switch_io_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                switchctrl,
    input  logic                switchread,
    input  logic [1:0]          switchaddr,
    input  logic [SW_WIDTH-1:0] switch_i,
    output logic [15:0]         switchrdata
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]       pre_q;
    logic [PW-1:0]       pre_d;
    logic                tick;
    logic [SW_WIDTH-1:0] sw_deb;
    logic [SW_WIDTH-1:0] sw_flip;
    logic                flag_rd;

    assign tick  = (pre_q == PRE_MAX);
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    // Prescaler producing one sample tick every TICK_DIV clocks.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar gi = 0; gi < SW_WIDTH; gi++) begin : g_bit
        switch_debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clock (clock),
            .reset (reset),
            .tick_i(tick),
            .raw_i (switch_i[gi]),
            .deb_o (sw_deb[gi]),
            .flip_o(sw_flip[gi])
        );
    end

`ifdef SWITCH_CHANGE_FLAG_EN
    logic flag_q;
    logic flag_d;
    logic flag_clr;

    assign flag_clr = switchctrl && switchread
                   && (switchaddr == SW_OFF_HI);

    // A flip on the same edge as a clearing read keeps the flag set.
    always_comb begin
        flag_d = flag_q;
        if (|sw_flip) begin
            flag_d = 1'b1;
        end else if (flag_clr) begin
            flag_d = 1'b0;
        end
    end

    // Sticky change flag register.
    always_ff @(posedge clock) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag_rd = flag_q;
`else
    logic unused_nc;
    assign unused_nc = ^{switchread, sw_flip};
    assign flag_rd   = 1'b0;
`endif

    // Zero-latency read mux straight from the debounced registers.
    always_comb begin
        switchrdata = 16'h0000;
        if (switchctrl) begin
            case (switchaddr)
                SW_OFF_LO: begin
                    switchrdata = sw_deb[15:0];
                end
                SW_OFF_HI: begin
                    switchrdata           = {8'h00, sw_deb[23:16]};
                    switchrdata[FLAG_BIT] = flag_rd;
                end
                default: begin
                    switchrdata = 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_io.sv
// Directed self-checking bench for switch_io (TICK_DIV=4, STABLE_TICKS=3).
// Covers both builds; SWITCH_CHANGE_FLAG_EN selects the flag expectations.
module tb_switch_io;

`ifdef SWITCH_CHANGE_FLAG_EN
    localparam logic FLAG_EN = 1'b1;
`else
    localparam logic FLAG_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        switchctrl;
    logic        switchread;
    logic [1:0]  switchaddr;
    logic [23:0] switch_i;
    logic [15:0] switchrdata;

    int compared = 0;
    int mismatched = 0;
    logic exp_flag;

    switch_io #(
        .TICK_DIV    (4),
        .STABLE_TICKS(3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .switchctrl (switchctrl),
        .switchread (switchread),
        .switchaddr (switchaddr),
        .switch_i   (switch_i),
        .switchrdata(switchrdata)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic ctrl, input logic [1:0] addr);
        switchctrl = ctrl;
        switchaddr = addr;
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        compared++;
        assert (switchrdata === exp) else begin
            mismatched++;
            $error("FAIL %s got %h want %h", tag, switchrdata, exp);
        end
    endtask

    // Waits for the read bus to equal want; the edge count must be 10..14.
    task automatic poll(input string tag, input logic [15:0] want);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (switchrdata === want) begin
                n = i;
                break;
            end
        end
        compared++;
        assert (n >= 10 && n <= 14) else begin
            mismatched++;
            $error("FAIL %s latency got %0d want 10..14 (bus %h want %h)",
                   tag, n, switchrdata, want);
        end
    endtask

    initial begin
        reset      = 1'b1;
        switchctrl = 1'b0;
        switchread = 1'b0;
        switchaddr = 2'b00;
        switch_i   = 24'h000000;
        exp_flag   = 1'b0;
        step();
        step();
        reset = 1'b0;

        rd(1'b1, 2'b00);
        check("reset_lo", 16'h0000);
        rd(1'b1, 2'b10);
        check("reset_hi", 16'h0000);

        rd(1'b1, 2'b00);
        switch_i = 24'hA51234;
        poll("step_lat", 16'h1234);
        exp_flag = FLAG_EN;
        check("step_lo", 16'h1234);
        rd(1'b1, 2'b10);
        check("step_hi", {exp_flag, 7'h00, 8'hA5});
        rd(1'b0, 2'b00);
        check("nocs_lo", 16'h0000);
        rd(1'b0, 2'b10);
        check("nocs_hi", 16'h0000);

        rd(1'b1, 2'b00);
        switch_i = 24'hA51235;
        for (int i = 0; i < 25; i++) begin
            if (i == 5) switch_i = 24'hA51234;
            step();
            check("glitch", 16'h1234);
        end

        rd(1'b1, 2'b01);
        check("odd_01", 16'h0000);
        rd(1'b1, 2'b11);
        check("odd_11", 16'h0000);

        rd(1'b1, 2'b00);
        switch_i = 24'hFFFFFF;
        for (int i = 0; i < 7; i++) step();
        check("pre_rst_lo", 16'h1234);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_flag = 1'b0;
        check("mid_rst_lo", 16'h0000);
        rd(1'b1, 2'b10);
        check("mid_rst_hi", 16'h0000);
        rd(1'b1, 2'b00);
        poll("rst_lat", 16'hFFFF);
        exp_flag = FLAG_EN;
        check("rst_lo", 16'hFFFF);
        rd(1'b1, 2'b10);
        check("rst_hi", {exp_flag, 7'h00, 8'hFF});

        switchread = 1'b1;
        rd(1'b1, 2'b10);
        check("clr_read", {exp_flag, 7'h00, 8'hFF});
        step();
        check("after_clr", 16'h00FF);
        switch_i = 24'h000000;
        poll("flip_clr", {FLAG_EN, 15'h0000});
        check("flip_clr_hi", {FLAG_EN, 15'h0000});
        step();
        check("final_clr", 16'h0000);
        switchread = 1'b0;
        rd(1'b1, 2'b00);
        check("final_lo", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
